// File: rtl/morse_rx_decoder.sv
// Morse receiver: synchronizes and debounces a key line, times marks and gaps in dot units,
// and delivers one ASCII byte per letter (plus 0x20 per word gap) over a valid/ready port.
module morse_rx_decoder #(
   parameter int UNIT_CYCLES     = 4000000,
   parameter int DEBOUNCE_CYCLES = 400
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_in,
   output logic [7:0] char_data,
   output logic       char_valid,
   input  logic       char_ready,
   output logic       overrun
);

   localparam int CW = (UNIT_CYCLES > 1) ? $clog2(UNIT_CYCLES) : 1;
   localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [CW-1:0] CYC_LAST = CW'(UNIT_CYCLES - 1);
   localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MARK,
      S_GAP,
      S_WORDGAP
   } state_t;

   state_t          state_q, state_d;
   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic            key_f_q, key_f_d;
   logic [DW-1:0]   deb_q, deb_d;
   logic [CW-1:0]   cyc_q, cyc_d;
   logic [2:0]      unit_q, unit_d;
   logic [2:0]      len_q, len_d;
   logic [5:0]      bits_q, bits_d;
   logic [7:0]      char_data_q, char_data_d;
   logic            char_valid_q, char_valid_d;
   logic            overrun_q, overrun_d;

   logic            key_rise;
   logic            key_fall;
   logic            unit_tick;
   logic [2:0]      unit_inc;
   logic            is_dash;
   logic            emit;
   logic [7:0]      emit_byte;
   logic            accept;

   // Pattern is keyed by element count and the elements packed MSB-first (1 = dash).
   function automatic logic [7:0] decode_symbol(input logic [2:0] len, input logic [5:0] bits);
      logic [7:0] ch;
      case ({len, bits})
         {3'd1, 6'b000000}: ch = 8'h45;
         {3'd1, 6'b000001}: ch = 8'h54;
         {3'd2, 6'b000000}: ch = 8'h49;
         {3'd2, 6'b000001}: ch = 8'h41;
         {3'd2, 6'b000010}: ch = 8'h4E;
         {3'd2, 6'b000011}: ch = 8'h4D;
         {3'd3, 6'b000000}: ch = 8'h53;
         {3'd3, 6'b000001}: ch = 8'h55;
         {3'd3, 6'b000010}: ch = 8'h52;
         {3'd3, 6'b000011}: ch = 8'h57;
         {3'd3, 6'b000100}: ch = 8'h44;
         {3'd3, 6'b000101}: ch = 8'h4B;
         {3'd3, 6'b000110}: ch = 8'h47;
         {3'd3, 6'b000111}: ch = 8'h4F;
         {3'd4, 6'b000000}: ch = 8'h48;
         {3'd4, 6'b000001}: ch = 8'h56;
         {3'd4, 6'b000010}: ch = 8'h46;
         {3'd4, 6'b000100}: ch = 8'h4C;
         {3'd4, 6'b000110}: ch = 8'h50;
         {3'd4, 6'b000111}: ch = 8'h4A;
         {3'd4, 6'b001000}: ch = 8'h42;
         {3'd4, 6'b001001}: ch = 8'h58;
         {3'd4, 6'b001010}: ch = 8'h43;
         {3'd4, 6'b001011}: ch = 8'h59;
         {3'd4, 6'b001100}: ch = 8'h5A;
         {3'd4, 6'b001101}: ch = 8'h51;
         {3'd5, 6'b011111}: ch = 8'h30;
         {3'd5, 6'b001111}: ch = 8'h31;
         {3'd5, 6'b000111}: ch = 8'h32;
         {3'd5, 6'b000011}: ch = 8'h33;
         {3'd5, 6'b000001}: ch = 8'h34;
         {3'd5, 6'b000000}: ch = 8'h35;
         {3'd5, 6'b010000}: ch = 8'h36;
         {3'd5, 6'b011000}: ch = 8'h37;
         {3'd5, 6'b011100}: ch = 8'h38;
         {3'd5, 6'b011110}: ch = 8'h39;
         default:           ch = 8'h3F;
      endcase
      return ch;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q      <= S_IDLE;
         sync1_q      <= 1'b0;
         sync2_q      <= 1'b0;
         key_f_q      <= 1'b0;
         deb_q        <= '0;
         cyc_q        <= '0;
         unit_q       <= 3'd0;
         len_q        <= 3'd0;
         bits_q       <= 6'd0;
         char_data_q  <= 8'h00;
         char_valid_q <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         sync1_q      <= sync1_d;
         sync2_q      <= sync2_d;
         key_f_q      <= key_f_d;
         deb_q        <= deb_d;
         cyc_q        <= cyc_d;
         unit_q       <= unit_d;
         len_q        <= len_d;
         bits_q       <= bits_d;
         char_data_q  <= char_data_d;
         char_valid_q <= char_valid_d;
         overrun_q    <= overrun_d;
      end
   end

   // Filtered level only moves after the synchronized key disagrees for the full debounce run.
   always_comb begin
      sync1_d = key_in;
      sync2_d = sync1_q;
      key_f_d = key_f_q;
      deb_d   = '0;
      if (sync2_q != key_f_q) begin
         if (deb_q == DEB_LAST) begin
            key_f_d = sync2_q;
         end else begin
            deb_d = deb_q + 1'b1;
         end
      end
   end

   assign key_rise = key_f_d & ~key_f_q;
   assign key_fall = ~key_f_d & key_f_q;

   always_comb begin
      unit_tick = (cyc_q == CYC_LAST);
      unit_inc  = (unit_q == 3'd7) ? 3'd7 : unit_q + 3'd1;
      cyc_d     = cyc_q + 1'b1;
      unit_d    = unit_q;
      if (key_rise || key_fall) begin
         cyc_d  = '0;
         unit_d = 3'd0;
      end else if (unit_tick) begin
         cyc_d  = '0;
         unit_d = unit_inc;
      end
   end

   // Dash test includes a wrap landing on the falling-edge cycle, so exactly 2 units is a dash.
   assign is_dash = ((unit_tick ? unit_inc : unit_q) >= 3'd2);

   always_comb begin
      state_d   = state_q;
      len_d     = len_q;
      bits_d    = bits_q;
      emit      = 1'b0;
      emit_byte = 8'h00;
      case (state_q)
         S_IDLE: begin
            len_d  = 3'd0;
            bits_d = 6'd0;
            if (key_rise) begin
               state_d = S_MARK;
            end
         end
         S_MARK: begin
            if (key_fall) begin
               if (len_q >= 3'd6) begin
                  len_d = 3'd7;
               end else begin
                  bits_d = {bits_q[4:0], is_dash};
                  len_d  = len_q + 3'd1;
               end
               state_d = S_GAP;
            end
         end
         S_GAP: begin
            if (unit_q >= 3'd2) begin
               emit      = 1'b1;
               emit_byte = decode_symbol(len_q, bits_q);
               len_d     = 3'd0;
               bits_d    = 6'd0;
               state_d   = key_rise ? S_MARK : S_WORDGAP;
            end else if (key_rise) begin
               state_d = S_MARK;
            end
         end
         S_WORDGAP: begin
            if (key_rise) begin
               state_d = S_MARK;
            end else if (unit_q >= 3'd5) begin
               emit      = 1'b1;
               emit_byte = 8'h20;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Single-entry output holding register; a byte arriving while it is full is lost.
   always_comb begin
      accept       = char_valid_q & char_ready;
      char_data_d  = char_data_q;
      char_valid_d = char_valid_q;
      overrun_d    = overrun_q;
      if (emit) begin
         if (!char_valid_q || accept) begin
            char_data_d  = emit_byte;
            char_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (accept) begin
         char_valid_d = 1'b0;
      end
   end

   assign char_data  = char_data_q;
   assign char_valid = char_valid_q;
   assign overrun    = overrun_q;

endmodule

// File: tb/tb_morse_rx_decoder.sv
// Scoreboard bench for morse_rx_decoder: stimulus pushes expected bytes derived from an ITU
// lookup table, a negedge monitor pops and compares every accepted byte.
module tb_morse_rx_decoder;

   localparam int UNIT = 8;
   localparam int DEB  = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       key_in = 1'b0;
   logic       char_ready = 1'b0;
   logic [7:0] char_data;
   logic       char_valid;
   logic       overrun;

   int         checks = 0;
   int         errors = 0;
   logic [7:0] exp_q[$];

   string alphabet = "ABCDEFGHIJKLMNOPQRSTUVWXYZ0123456789";
   string morse_tab [36] = '{
      ".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
      "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
      "..-", "...-", ".--", "-..-", "-.--", "--..",
      "-----", ".----", "..---", "...--", "....-",
      ".....", "-....", "--...", "---..", "----."
   };

   morse_rx_decoder #(
      .UNIT_CYCLES(UNIT),
      .DEBOUNCE_CYCLES(DEB)
   ) dut (
      .clk(clk),
      .rst(rst),
      .key_in(key_in),
      .char_data(char_data),
      .char_valid(char_valid),
      .char_ready(char_ready),
      .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Every byte the consumer takes must be the next one the model predicted.
   always @(negedge clk) begin
      if (rst && char_valid && char_ready) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("[TB] FAIL unexpected_byte actual=%02h required=none", char_data);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (char_data !== e) begin
               errors++;
               $display("[TB] FAIL byte actual=%02h required=%02h", char_data, e);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic logic [7:0] refDecode(input string pat);
      for (int i = 0; i < 36; i++) begin
         if (morse_tab[i] == pat) return alphabet[i];
      end
      return 8'h3F;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
      end
   endtask

   // Sends one symbol with randomized element timing, then holds the key low for gap_after cycles.
   task automatic applyStimulus(input string pat, input int gap_after, input bit push_char);
      if (push_char) exp_q.push_back(refDecode(pat));
      if (gap_after >= 5 * UNIT) exp_q.push_back(8'h20);
      for (int i = 0; i < pat.len(); i++) begin
         key_in = 1'b1;
         if (pat[i] == "-") tick($urandom_range(28, 18));
         else               tick($urandom_range(10, 6));
         key_in = 1'b0;
         if (i != pat.len() - 1) tick($urandom_range(12, 6));
      end
      tick(gap_after);
   endtask

   task automatic waitDrain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || char_valid) && n < 400) begin
         tick(1);
         n++;
      end
      checkOutput("drain_pending", exp_q.size(), 0);
   endtask

   initial begin
      int  first;
      int  second;
      logic prev;
      string pat;
      int  gap;

      rst = 1'b0;
      key_in = 1'b0;
      char_ready = 1'b1;
      tick(4);
      rst = 1'b1;
      tick(1);
      checkOutput("reset_valid", char_valid, 0);
      checkOutput("reset_data", char_data, 8'h00);
      checkOutput("reset_overrun", overrun, 0);

      $display("[TB] single E with latency measurement");
      exp_q.push_back(8'h45);
      exp_q.push_back(8'h20);
      key_in = 1'b1;
      tick(8);
      key_in = 1'b0;
      first = 0;
      second = 0;
      prev = char_valid;
      for (int k = 1; k <= 60; k++) begin
         tick(1);
         if (char_valid && !prev) begin
            if (first == 0) first = k;
            else if (second == 0) second = k;
         end
         prev = char_valid;
      end
      checkOutput("e_latency", first, 2 + DEB + 2 * UNIT + 1);
      checkOutput("space_latency", second, 2 + DEB + 5 * UNIT + 1);
      checkOutput("e_overrun", overrun, 0);
      waitDrain();

      $display("[TB] SOS");
      applyStimulus("...", 24, 1'b1);
      applyStimulus("---", 24, 1'b1);
      applyStimulus("...", 60, 1'b1);
      waitDrain();

      $display("[TB] digits and overflow");
      applyStimulus(".....", 60, 1'b1);
      applyStimulus("-....", 60, 1'b1);
      applyStimulus(".......", 60, 1'b1);
      waitDrain();

      $display("[TB] backpressure");
      char_ready = 1'b0;
      applyStimulus("-", 24, 1'b1);
      applyStimulus(".", 26, 1'b0);
      checkOutput("bp_valid", char_valid, 1);
      checkOutput("bp_data", char_data, 8'h54);
      checkOutput("bp_overrun", overrun, 1);
      exp_q.push_back(8'h20);
      char_ready = 1'b1;
      tick(2);
      checkOutput("bp_cleared", char_valid, 0);
      tick(40);
      waitDrain();

      $display("[TB] glitch rejection");
      for (int g = 0; g < 5; g++) begin
         key_in = 1'b1;
         tick(1);
         key_in = 1'b0;
         tick($urandom_range(10, 4));
      end
      exp_q.push_back(8'h54);
      exp_q.push_back(8'h20);
      key_in = 1'b1;
      tick(10);
      key_in = 1'b0;
      tick(1);
      key_in = 1'b1;
      tick(13);
      key_in = 1'b0;
      tick(60);
      waitDrain();

      $display("[TB] reset mid-symbol");
      key_in = 1'b1;
      tick(8);
      key_in = 1'b0;
      tick(8);
      key_in = 1'b1;
      tick(10);
      rst = 1'b0;
      key_in = 1'b0;
      tick(1);
      rst = 1'b1;
      checkOutput("rst_valid", char_valid, 0);
      checkOutput("rst_data", char_data, 8'h00);
      checkOutput("rst_overrun", overrun, 0);
      tick(60);
      applyStimulus(".", 60, 1'b1);
      waitDrain();

      $display("[TB] randomized symbols");
      for (int n = 0; n < 20; n++) begin
         if ($urandom_range(3) == 0) begin
            pat = "";
            for (int j = 0; j < int'($urandom_range(7, 1)); j++) begin
               if ($urandom_range(1) == 1) pat = {pat, "-"};
               else                        pat = {pat, "."};
            end
         end else begin
            pat = morse_tab[$urandom_range(35)];
         end
         if (n == 19 || $urandom_range(3) == 0) gap = 60;
         else                                   gap = int'($urandom_range(34, 20));
         applyStimulus(pat, gap, 1'b1);
      end
      waitDrain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
